// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with a fast path for divide-by-zero and signed overflow.
module ex_muldiv #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            stallreq,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [6:0]      LAST_ITER = 7'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic [2:0]      op_q;
    logic [XLEN-1:0] src1_q, src2_q;
    logic [XLEN-1:0] d_q;          // multiplicand (multiply) or divisor (divide) magnitude
    logic [XLEN-1:0] hi_q, lo_q;   // product halves, or partial remainder / quotient
    logic            neg_q, rem_neg_q;
    logic [6:0]      cnt_q;

    logic            accept;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        accept = (state_q == IDLE) && start && !flush;
        a_neg  = src1[XLEN-1] && (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        b_neg  = src2[XLEN-1] && (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
        a_mag  = a_neg ? -src1 : src1;
        b_mag  = b_neg ? -src2 : src2;
    end

    // Special divides finish on the first CALC edge without iterating.
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        div_zero = (src2_q == '0);
        div_ovf  = (op_q == OP_DIV || op_q == OP_REM) && (src1_q == MOST_NEG) && (src2_q == '1);
        fast     = op_q[2] && (div_zero || div_ovf);
        if (op_q == OP_DIV || op_q == OP_DIVU) fast_res = div_zero ? '1 : src1_q;
        else                                   fast_res = div_zero ? src1_q : '0;
    end

    logic [XLEN:0]     sum, rem_sh, diff;
    logic [XLEN-1:0]   hi_n, lo_n;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, final_res;

    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    always_comb begin
        sum    = '0;
        rem_sh = '0;
        diff   = '0;
        hi_n   = hi_q;
        lo_n   = lo_q;
        if (!op_q[2]) begin
            sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo_q[XLEN-1:1]};
        end else begin
            rem_sh = {hi_q, lo_q[XLEN-1]};
            diff   = rem_sh - {1'b0, d_q};
            if (!diff[XLEN]) begin
                hi_n = diff[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_n = rem_sh[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b0};
            end
        end

        prod_s = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        quo_s  = neg_q ? -lo_n : lo_n;
        rem_s  = rem_neg_q ? -hi_n : hi_n;

        case (op_q)
            OP_MUL:                        final_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               final_res = quo_s;
            default:                       final_res = rem_s;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC: begin
                if (flush)                           state_d = IDLE;
                else if (fast || cnt_q == LAST_ITER) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            d_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            result    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q      <= op;
                src1_q    <= src1;
                src2_q    <= src2;
                d_q       <= op[2] ? b_mag : a_mag;
                hi_q      <= '0;
                lo_q      <= op[2] ? a_mag : b_mag;
                neg_q     <= a_neg ^ b_neg;
                rem_neg_q <= a_neg;
                cnt_q     <= '0;
            end else if (state_q == CALC && !flush) begin
                hi_q  <= hi_n;
                lo_q  <= lo_n;
                cnt_q <= cnt_q + 7'd1;
                if (fast)                    result <= fast_res;
                else if (cnt_q == LAST_ITER) result <= final_res;
            end
        end
    end

    assign stallreq = accept || (state_q == CALC);
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized self-checking bench for ex_muldiv against a plain-arithmetic reference model,
// plus directed latency, flush, reset and back-to-back scenarios.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [63:0] src1, src2;
    logic        stallreq, done;
    logic [63:0] result;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] last_exp = '0;

    ex_muldiv #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
        .flush(flush), .stallreq(stallreq), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb, p;
        longint sa, sb;
        sa = a;
        sb = b;
        ea = (o == 3'd3) ? {64'b0, a} : {{64{a[63]}}, a};
        eb = (o == 3'd2 || o == 3'd3) ? {64'b0, b} : {{64{b[63]}}, b};
        p  = ea * eb;
        case (o)
            3'd0: return p[63:0];
            3'd1, 3'd2, 3'd3: return p[127:64];
            3'd4: begin
                if (b == 0) return '1;
                if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
                return sa / sb;
            end
            3'd5: return (b == 0) ? '1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 64'h8000_0000_0000_0000 && b == '1) return 0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        if (o[2] && (b == 0 || ((o == 3'd4 || o == 3'd6) && a == 64'h8000_0000_0000_0000 && b == '1)))
            return 1;
        return 64;
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 64'($urandom_range(0, 20));
            1: return -64'($urandom_range(1, 20));
            2: return {$urandom, $urandom};
            3: return '0;
            4: return 64'h8000_0000_0000_0000;
            default: return '1;
        endcase
    endfunction

    // Presents a request in IDLE, lets the accepting edge pass, then scrambles the inputs.
    task automatic launch(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        op = o; src1 = a; src2 = b; start = 1'b1; flush = 1'b0;
        #1 check("stall_start", 64'(stallreq), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'($urandom);
        src1  = {$urandom, $urandom};
        src2  = {$urandom, $urandom};
    endtask

    // Edges after the accepting edge until done is seen; -1 on timeout.
    task automatic wait_done(output int lat, output int stall_low);
        lat = -1;
        stall_low = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k - 1;
                break;
            end
            if (!stallreq) stall_low++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        int lat, stall_low;
        logic [63:0] exp;
        exp = ref_model(o, a, b);
        launch(o, a, b);
        wait_done(lat, stall_low);
        check({tag, "_latency"}, 64'(lat), 64'(exp_latency(o, a, b)));
        check({tag, "_stall_calc"}, 64'(stall_low), 64'd0);
        check({tag, "_result"}, result, exp);
        check({tag, "_stall_done"}, 64'(stallreq), 64'd0);
        last_exp = exp;
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_result_hold"}, result, exp);
    endtask

    initial begin
        int lat, stall_low, done_seen;
        logic [63:0] exp_b;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src1 = '0; src2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_result", result, 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_stall", 64'(stallreq), 64'd0);
        start = 1'b1; op = 3'd0; src1 = 64'd3; src2 = 64'd3;
        #1 check("reset_over_start_stall", 64'(stallreq), 64'd1);
        @(posedge clk);
        #1 start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("reset_priority", 64'(stallreq), 64'd0);

        run_op("mul_7_m3", 3'd0, 64'd7, -64'd3);
        run_op("mulhu_ones", 3'd3, '1, '1);
        run_op("mulh_ones", 3'd1, '1, '1);
        run_op("div_m7_2", 3'd4, -64'd7, 64'd2);
        run_op("rem_m7_2", 3'd6, -64'd7, 64'd2);
        run_op("divu_100_7", 3'd5, 64'd100, 64'd7);
        run_op("remu_100_7", 3'd7, 64'd100, 64'd7);
        run_op("div_5_0", 3'd4, 64'd5, 64'd0);
        run_op("rem_5_0", 3'd6, 64'd5, 64'd0);
        run_op("div_ovf", 3'd4, 64'h8000_0000_0000_0000, '1);
        run_op("rem_ovf", 3'd6, 64'h8000_0000_0000_0000, '1);

        // start together with flush in IDLE is ignored
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'd0; src1 = 64'd9; src2 = 64'd9;
        #1 check("start_flush_stall", 64'(stallreq), 64'd0);
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("start_flush_idle", 64'(stallreq), 64'd0);

        // flush after 30 iterations
        run_op("pre_flush", 3'd2, -64'd5, 64'd11);
        launch(3'd0, 64'd123, 64'd456);
        repeat (30) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("flush_no_done", 64'(done_seen), 64'd0);
        check("flush_stall", 64'(stallreq), 64'd0);
        check("flush_result_kept", result, last_exp);
        run_op("after_flush", 3'd0, 64'd123, 64'd456);

        // reset after 10 iterations
        launch(3'd5, 64'd1000, 64'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_result", result, 64'd0);
        check("midrst_stall", 64'(stallreq), 64'd0);
        done_seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("midrst_no_done", 64'(done_seen), 64'd0);

        // back-to-back with start held high
        @(negedge clk);
        op = 3'd5; src1 = 64'd1000; src2 = 64'd3; start = 1'b1;
        @(posedge clk);
        wait_done(lat, stall_low);
        check("b2b_a_latency", 64'(lat), 64'd64);
        check("b2b_a_result", result, ref_model(3'd5, 64'd1000, 64'd3));
        check("b2b_done_stall", 64'(stallreq), 64'd0);
        op = 3'd6; src1 = -64'd50; src2 = 64'd7;
        exp_b = ref_model(3'd6, -64'd50, 64'd7);
        @(negedge clk);
        check("b2b_idle_done", 64'(done), 64'd0);
        check("b2b_idle_stall", 64'(stallreq), 64'd1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, stall_low);
        check("b2b_b_latency", 64'(lat), 64'd64);
        check("b2b_b_result", result, exp_b);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] o;
            o = 3'($urandom_range(0, 7));
            run_op($sformatf("rand%0d_op%0d", i, o), o, pick_operand(), pick_operand());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
